// File: rtl/core_run_ctrl_pkg.sv
// Shared state codes and constants for the core run/step/halt sequencer.
package core_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_STEP  = 3'd3,
    ST_HALT  = 3'd4
  } run_state_e;

  localparam logic [31:0] EBREAK_INSTR        = 32'h00100073;
  localparam int          DEBOUNCE_CYCLES_DEF = 4;
  localparam int          RST_CYCLES_DEF      = 2;
  localparam int          CNT_W_DEF           = 32;

endpackage

// File: rtl/core_run_ctrl_key_debounce.sv
// Push-button conditioning: 2-FF synchroniser, consecutive-sample debounce,
// and a single-cycle pulse when the debounced level rises.
module core_run_ctrl_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_evt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          evt_q, evt_d;

  always_comb begin
    sync1_d  = key;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    evt_d    = 1'b0;
    // Any sample agreeing with the stable level restarts the run length.
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
        evt_d    = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      evt_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
    end
  end

  assign key_evt = evt_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/step/halt sequencer: gates the core clock-enable, holds core reset after
// restart, stops on the halt opcode and counts enabled cycles.
module core_run_ctrl
  import core_run_ctrl_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int          RST_CYCLES      = RST_CYCLES_DEF,
  parameter logic [31:0] HALT_INSTR      = EBREAK_INSTR,
  parameter int          CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key,
  input  logic             mode_step,
  input  logic [15:0]      pc,
  input  logic [31:0]      instr,
  output logic             cpu_en,
  output logic             cpu_rst_n,
  output logic             halted,
  output logic [15:0]      halt_pc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [2:0]       state
);

  localparam int RCW = $clog2(RST_CYCLES + 1);

  run_state_e       state_q, state_d;
  logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
  logic             cpu_rst_n_q, cpu_rst_n_d;
  logic [15:0]      halt_pc_q, halt_pc_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             key_evt;
  logic             halt_hit;

  core_run_ctrl_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .key    (key),
    .key_evt(key_evt)
  );

  // The halting fetch is blocked in the same cycle so it never executes.
  assign halt_hit = (instr == HALT_INSTR);
  assign cpu_en   = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !halt_hit;

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    cpu_rst_n_d = cpu_rst_n_q;
    halt_pc_d   = halt_pc_q;
    cycle_cnt_d = cycle_cnt_q;
    if (cpu_en && (cycle_cnt_q != '1)) begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
    end
    // Key events outside RUN/PAUSE/HALT, or losing to halt_hit, are dropped.
    case (state_q)
      ST_RST: begin
        if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
          state_d     = mode_step ? ST_PAUSE : ST_RUN;
          cpu_rst_n_d = 1'b1;
          rst_cnt_d   = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (halt_hit) begin
          state_d   = ST_HALT;
          halt_pc_d = pc;
        end else if (key_evt) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (key_evt) begin
          state_d = mode_step ? ST_STEP : ST_RUN;
        end
      end
      ST_STEP: begin
        if (halt_hit) begin
          state_d   = ST_HALT;
          halt_pc_d = pc;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_HALT: begin
        if (key_evt) begin
          state_d     = ST_RST;
          cpu_rst_n_d = 1'b0;
          rst_cnt_d   = '0;
          cycle_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RST;
      rst_cnt_q   <= '0;
      cpu_rst_n_q <= 1'b0;
      halt_pc_q   <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      halt_pc_q   <= halt_pc_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign cpu_rst_n = cpu_rst_n_q;
  assign halted    = (state_q == ST_HALT);
  assign halt_pc   = halt_pc_q;
  assign cycle_cnt = cycle_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed scenarios plus random traffic, checked
// against a cycle-level behavioural model through expected-value queues.
module tb_core_run_ctrl;

  localparam int          DEB  = 4;
  localparam int          RSTC = 2;
  localparam logic [31:0] HALT = 32'h00100073;
  localparam int          EXP_W = 3 + 1 + 1 + 16 + 32 + 4;

  logic        clk = 1'b0;
  logic        rst_n, key, mode_step;
  logic [15:0] pc;
  logic [31:0] instr;

  logic        cpu_en, cpu_rst_n, halted;
  logic [15:0] halt_pc;
  logic [31:0] cycle_cnt;
  logic [2:0]  state;

  logic        cpu_en_s, cpu_rst_n_s, halted_s;
  logic [15:0] halt_pc_s;
  logic [3:0]  cycle_cnt_s;
  logic [2:0]  state_s;

  int errors = 0;
  int checks = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic             exp_en_q[$];

  always #5 clk = ~clk;

  core_run_ctrl #(.DEBOUNCE_CYCLES(DEB), .RST_CYCLES(RSTC), .HALT_INSTR(HALT), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .mode_step(mode_step), .pc(pc), .instr(instr),
    .cpu_en(cpu_en), .cpu_rst_n(cpu_rst_n), .halted(halted), .halt_pc(halt_pc),
    .cycle_cnt(cycle_cnt), .state(state)
  );

  core_run_ctrl #(.DEBOUNCE_CYCLES(DEB), .RST_CYCLES(RSTC), .HALT_INSTR(HALT), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .key(key), .mode_step(mode_step), .pc(pc), .instr(instr),
    .cpu_en(cpu_en_s), .cpu_rst_n(cpu_rst_n_s), .halted(halted_s), .halt_pc(halt_pc_s),
    .cycle_cnt(cycle_cnt_s), .state(state_s)
  );

  // ---------------- behavioural reference model ----------------
  // States: 0 reset-hold, 1 run, 2 pause, 3 step, 4 halt.
  int          m_state = 0;
  bit          m_rst_out = 0;
  logic [15:0] m_halt_pc = '0;
  longint      m_cnt32 = 0;
  int          m_cnt4 = 0;
  int          m_rst_age = 0;
  bit          m_stable = 0;
  bit          m_evt = 0;
  bit          key_delay[$] = '{1'b0, 1'b0};
  bit          sync_hist[$];

  function automatic bit model_en(input int st, input logic [31:0] ins);
    return ((st == 1) || (st == 3)) && (ins != HALT);
  endfunction

  always @(posedge clk) begin
    bit evt_now, sync_v, all_diff, en, new_evt;
    if (!rst_n) begin
      m_state = 0; m_rst_out = 0; m_halt_pc = '0; m_cnt32 = 0; m_cnt4 = 0;
      m_rst_age = 0; m_stable = 0; m_evt = 0;
      key_delay = '{1'b0, 1'b0};
      sync_hist = {};
    end else begin
      evt_now = m_evt;
      // Debounced level follows the synchronised key after DEB disagreeing samples in a row.
      sync_v = key_delay[0];
      key_delay.push_back(key);
      void'(key_delay.pop_front());
      sync_hist.push_back(sync_v);
      if (sync_hist.size() > DEB) void'(sync_hist.pop_front());
      new_evt = 0;
      if (sync_hist.size() == DEB) begin
        all_diff = 1;
        foreach (sync_hist[i]) if (sync_hist[i] == m_stable) all_diff = 0;
        if (all_diff) begin
          m_stable = sync_v;
          new_evt  = sync_v;
        end
      end
      m_evt = new_evt;

      en = model_en(m_state, instr);
      if (en) begin
        if (m_cnt32 < 64'hFFFF_FFFF) m_cnt32++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      case (m_state)
        0: begin
          m_rst_age++;
          if (m_rst_age >= RSTC) begin
            m_state = mode_step ? 2 : 1;
            m_rst_out = 1;
          end
        end
        1: if (instr == HALT) begin m_state = 4; m_halt_pc = pc; end
           else if (evt_now) m_state = 2;
        2: if (evt_now) m_state = mode_step ? 3 : 1;
        3: if (instr == HALT) begin m_state = 4; m_halt_pc = pc; end
           else m_state = 2;
        4: if (evt_now) begin
             m_state = 0; m_rst_age = 0; m_rst_out = 0; m_cnt32 = 0; m_cnt4 = 0;
           end
        default: m_state = 0;
      endcase
    end
    exp_q.push_back({3'(m_state), m_rst_out, (m_state == 4), m_halt_pc,
                     m_cnt32[31:0], 4'(m_cnt4)});
  end

  // ---------------- scoreboard monitor ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic [EXP_W-1:0] e;
    logic             ee;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("exp_q_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("state",         32'(state),       32'(e[EXP_W-1 -: 3]));
        chk("cpu_rst_n",     32'(cpu_rst_n),   32'(e[EXP_W-4]));
        chk("halted",        32'(halted),      32'(e[EXP_W-5]));
        chk("halt_pc",       32'(halt_pc),     32'(e[EXP_W-6 -: 16]));
        chk("cycle_cnt",     cycle_cnt,        e[35:4]);
        chk("sat_state",     32'(state_s),     32'(e[EXP_W-1 -: 3]));
        chk("sat_cpu_rst_n", 32'(cpu_rst_n_s), 32'(e[EXP_W-4]));
        chk("sat_halted",    32'(halted_s),    32'(e[EXP_W-5]));
        chk("sat_halt_pc",   32'(halt_pc_s),   32'(e[EXP_W-6 -: 16]));
        chk("sat_cycle_cnt", 32'(cycle_cnt_s), 32'(e[3:0]));
      end
      @(negedge clk);
      #2;
      if (exp_en_q.size() == 0) begin
        chk("exp_en_q_empty", 32'd1, 32'd0);
      end else begin
        ee = exp_en_q.pop_front();
        chk("cpu_en",     32'(cpu_en),   32'(ee));
        chk("sat_cpu_en", 32'(cpu_en_s), 32'(ee));
      end
    end
  end

  // ---------------- driver ----------------
  function automatic logic [31:0] rand_instr();
    logic [31:0] v;
    v = $urandom();
    if (v == HALT) v = 32'h0000_0013;
    return v;
  endfunction

  task automatic drive(input bit r, input bit k, input bit ms,
                       input logic [15:0] p, input logic [31:0] ins);
    @(negedge clk);
    rst_n = r; key = k; mode_step = ms; pc = p; instr = ins;
    #1;
    exp_en_q.push_back(model_en(m_state, instr));
  endtask

  task automatic idle(input int n, input bit k, input bit ms);
    for (int i = 0; i < n; i++) drive(1'b1, k, ms, 16'($urandom()), rand_instr());
  endtask

  task automatic press(input int hold, input int gap, input bit ms);
    idle(hold, 1'b1, ms);
    idle(gap, 1'b0, ms);
  endtask

  initial begin
    bit k, ms, r;
    rst_n = 1'b0; key = 1'b0; mode_step = 1'b0; pc = '0; instr = '0;

    // Reset held two cycles, then free-run after the reset-hold window.
    drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    idle(8, 1'b0, 1'b0);

    // Bouncing press: one pause event only.
    for (int i = 0; i < 6; i++) drive(1'b1, (i % 2) == 0, 1'b0, 16'($urandom()), rand_instr());
    idle(12, 1'b1, 1'b0);
    idle(10, 1'b0, 1'b0);

    // Single-step: three clean presses.
    for (int i = 0; i < 3; i++) press(8, 8, 1'b1);

    // Back to free-run, then halt at pc 0x0040.
    press(8, 4, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h0040, HALT);
    idle(4, 1'b0, 1'b0);

    // Restart from halt, run, then a press whose event lands on a halt fetch.
    press(8, 8, 1'b0);
    for (int i = 0; i < 12; i++)
      drive(1'b1, 1'b1, 1'b0, 16'h0100 + 16'(i), (i >= 6) ? HALT : rand_instr());
    idle(8, 1'b0, 1'b0);
    press(8, 4, 1'b0);

    // Long free-run saturates the narrow counter, then reset mid-run.
    idle(25, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h1234, rand_instr());
    idle(6, 1'b0, 1'b0);

    // Random traffic.
    k = 0; ms = 0;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 5) == 0) k = ~k;
      if ($urandom_range(0, 39) == 0) ms = ~ms;
      drive(r, k, ms, 16'($urandom()), ($urandom_range(0, 14) == 0) ? HALT : rand_instr());
    end

    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
